tlk2711_axil_reg_bridge: RTL and testbench



---
 rtl/tlk2711_axil_pkg.sv | 6 +
 rtl/tlk2711_axil_hold.sv | 29 ++
 rtl/tlk2711_axil_reg_bridge.sv | 119 +++++++++++
 tb/tb_tlk2711_axil_reg_bridge.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tlk2711_axil_pkg.sv
// tlk2711_axil_pkg: shared FSM state type and AXI response codes for the register bridge
package tlk2711_axil_pkg;
  typedef enum logic [1:0] {IDLE, WR_RESP, RD_WAIT, RD_RESP} state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/tlk2711_axil_hold.sv
// tlk2711_axil_hold: one-entry valid/ready holding register, released by clr
module tlk2711_axil_hold #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic         ready,
  output logic         held,
  output logic [W-1:0] dout
);
  // capture on handshake, release on clr; ready mirrors ~held once out of reset
  always_ff @(posedge clk)
    if (rst) begin
      held <= 1'b0;
      ready <= 1'b0;
      dout <= '0;
    end else if (valid & ready) begin
      held <= 1'b1;
      ready <= 1'b0;
      dout <= din;
    end else if (clr) begin
      held <= 1'b0;
      ready <= 1'b1;
    end else
      ready <= ~held;
endmodule

// File: rtl/tlk2711_axil_reg_bridge.sv
// tlk2711_axil_reg_bridge: AXI4-Lite slave to single-cycle register strobe bridge for the TLK2711 core
module tlk2711_axil_reg_bridge
  import tlk2711_axil_pkg::*;
#(
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int REG_ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH      = 64,
  parameter int RD_LATENCY      = 1
) (
  input  logic                       ps_clk,
  input  logic                       ps_rst,
  input  logic                       s_axil_awvalid,
  output logic                       s_axil_awready,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                       s_axil_wvalid,
  output logic                       s_axil_wready,
  input  logic [DATA_WIDTH-1:0]      s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]    s_axil_wstrb,
  output logic                       s_axil_bvalid,
  input  logic                       s_axil_bready,
  output logic [1:0]                 s_axil_bresp,
  input  logic                       s_axil_arvalid,
  output logic                       s_axil_arready,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
  output logic                       s_axil_rvalid,
  input  logic                       s_axil_rready,
  output logic [DATA_WIDTH-1:0]      s_axil_rdata,
  output logic [1:0]                 s_axil_rresp,
  output logic                       o_reg_wen,
  output logic [REG_ADDR_WIDTH-1:0]  o_reg_waddr,
  output logic [DATA_WIDTH-1:0]      o_reg_wdata,
  output logic                       o_reg_ren,
  output logic [REG_ADDR_WIDTH-1:0]  o_reg_raddr,
  input  logic [DATA_WIDTH-1:0]      i_reg_rdata
);
  localparam int S = DATA_WIDTH / 8;
  localparam logic [2:0] LAT = 3'(RD_LATENCY);
  state_t state;
  logic aw_held, w_held, last_wr, run, rd_err;
  logic [2:0] cnt;
  logic [AXIL_ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH+S-1:0] wq;
  logic b_done, wr_rdy, ar_go, wr_ok, rd_ok;
  assign b_done = s_axil_bvalid & s_axil_bready;
  assign wr_rdy = aw_held & w_held;
  assign s_axil_arready = run & (state == IDLE) & ~(wr_rdy & ~last_wr);
  assign ar_go = s_axil_arvalid & s_axil_arready;
  assign wr_ok = (&wq[DATA_WIDTH+S-1:DATA_WIDTH]) & (awaddr_q[AXIL_ADDR_WIDTH-1:REG_ADDR_WIDTH] == '0);
  assign rd_ok = s_axil_araddr[AXIL_ADDR_WIDTH-1:REG_ADDR_WIDTH] == '0;
  tlk2711_axil_hold #(.W(AXIL_ADDR_WIDTH)) u_aw (
    .clk(ps_clk), .rst(ps_rst), .valid(s_axil_awvalid), .clr(b_done), .din(s_axil_awaddr),
    .ready(s_axil_awready), .held(aw_held), .dout(awaddr_q)
  );
  tlk2711_axil_hold #(.W(DATA_WIDTH + S)) u_w (
    .clk(ps_clk), .rst(ps_rst), .valid(s_axil_wvalid), .clr(b_done), .din({s_axil_wstrb, s_axil_wdata}),
    .ready(s_axil_wready), .held(w_held), .dout(wq)
  );
  // access FSM: round-robin grant, one outstanding core access, registered strobes and responses
  always_ff @(posedge ps_clk)
    if (ps_rst) begin
      state <= IDLE;
      run <= 1'b0;
      last_wr <= 1'b0;
      rd_err <= 1'b0;
      cnt <= '0;
      o_reg_wen <= 1'b0;
      o_reg_ren <= 1'b0;
      o_reg_waddr <= '0;
      o_reg_wdata <= '0;
      o_reg_raddr <= '0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp <= RESP_OKAY;
      s_axil_rvalid <= 1'b0;
      s_axil_rdata <= '0;
      s_axil_rresp <= RESP_OKAY;
    end else begin
      run <= 1'b1;
      o_reg_wen <= 1'b0;
      o_reg_ren <= 1'b0;
      case (state)
        IDLE:
          if (ar_go) begin
            state <= RD_WAIT;
            last_wr <= 1'b0;
            o_reg_ren <= rd_ok;
            o_reg_raddr <= s_axil_araddr[REG_ADDR_WIDTH-1:0];
            rd_err <= ~rd_ok;
            cnt <= '0;
          end else if (wr_rdy) begin
            state <= WR_RESP;
            last_wr <= 1'b1;
            o_reg_wen <= wr_ok;
            o_reg_waddr <= awaddr_q[REG_ADDR_WIDTH-1:0];
            o_reg_wdata <= wq[DATA_WIDTH-1:0];
            s_axil_bvalid <= 1'b1;
            s_axil_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
          end
        WR_RESP:
          if (b_done) begin
            s_axil_bvalid <= 1'b0;
            state <= IDLE;
          end
        RD_WAIT:
          if (cnt == LAT) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rdata <= rd_err ? '0 : i_reg_rdata;
            s_axil_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
            state <= RD_RESP;
          end else
            cnt <= cnt + 3'd1;
        RD_RESP:
          if (s_axil_rvalid & s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_tlk2711_axil_reg_bridge.sv
// tb_tlk2711_axil_reg_bridge: directed self-checking bench for the AXI4-Lite register bridge
module tb_tlk2711_axil_reg_bridge;
  logic ps_clk = 1'b0;
  logic ps_rst = 1'b1;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr;
  logic [63:0] wdata, rdata, reg_wdata, reg_rdata, core_val;
  logic [7:0] wstrb;
  logic [1:0] bresp, rresp;
  logic reg_wen, reg_ren;
  logic [15:0] reg_waddr, reg_raddr;
  logic [2:0] pipe = '0;
  int checks = 0;
  int errors = 0;
  int wen_cnt = 0;
  int ren_cnt = 0;
  int both_cnt = 0;
  int nseq = 0;
  logic log_on = 1'b0;
  logic seq [0:63];
  always #5 ps_clk = ~ps_clk;
  tlk2711_axil_reg_bridge #(.AXIL_ADDR_WIDTH(32), .REG_ADDR_WIDTH(16), .DATA_WIDTH(64), .RD_LATENCY(3)) dut (
    .ps_clk(ps_clk), .ps_rst(ps_rst),
    .s_axil_awvalid(awvalid), .s_axil_awready(awready), .s_axil_awaddr(awaddr),
    .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
    .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_bresp(bresp),
    .s_axil_arvalid(arvalid), .s_axil_arready(arready), .s_axil_araddr(araddr),
    .s_axil_rvalid(rvalid), .s_axil_rready(rready), .s_axil_rdata(rdata), .s_axil_rresp(rresp),
    .o_reg_wen(reg_wen), .o_reg_waddr(reg_waddr), .o_reg_wdata(reg_wdata),
    .o_reg_ren(reg_ren), .o_reg_raddr(reg_raddr), .i_reg_rdata(reg_rdata)
  );
  assign reg_rdata = pipe[2] ? core_val : 64'h0BAD_0BAD_0BAD_0BAD;
  always @(posedge ps_clk) begin
    pipe <= {pipe[1:0], reg_ren};
    if (reg_wen) wen_cnt <= wen_cnt + 1;
    if (reg_ren) ren_cnt <= ren_cnt + 1;
    if (reg_wen && reg_ren) both_cnt <= both_cnt + 1;
    if (log_on && (reg_wen || reg_ren) && nseq < 64) begin
      seq[nseq] <= reg_wen;
      nseq <= nseq + 1;
    end
  end
  task automatic tick;
    @(negedge ps_clk);
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; core_val = 0;
    repeat (3) tick;
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_strobes", {reg_wen, reg_ren}, 0);
    chk("rst_rdata", rdata, 0);
    ps_rst = 0;
    tick;
    chk("up_readies", {awready, wready, arready}, 3'b111);
    awvalid = 1; awaddr = 32'h10; wvalid = 1; wdata = 64'h1122334455667788; wstrb = 8'hFF;
    tick;
    awvalid = 0; wvalid = 0;
    chk("t1_wen_early", reg_wen, 0);
    chk("t1_awready_held", awready, 0);
    tick;
    chk("t1_wen", reg_wen, 1);
    chk("t1_waddr", reg_waddr, 16'h0010);
    chk("t1_wdata", reg_wdata, 64'h1122334455667788);
    chk("t1_bvalid", bvalid, 1);
    chk("t1_bresp", bresp, 2'b00);
    tick;
    chk("t1_wen_once", reg_wen, 0);
    chk("t1_bvalid_hold", bvalid, 1);
    bready = 1;
    tick;
    chk("t1_bdone", bvalid, 0);
    bready = 0;
    chk("t1_wen_cnt", wen_cnt, 1);
    wvalid = 1; wdata = 64'hA5A5_0000_FFFF_0001; wstrb = 8'hFF;
    tick;
    wvalid = 0;
    chk("t2_wready_low", wready, 0);
    chk("t2_awready_up", awready, 1);
    tick;
    chk("t2_no_wen", reg_wen, 0);
    awvalid = 1; awaddr = 32'h38;
    tick;
    awvalid = 0;
    chk("t2_awready_low", awready, 0);
    tick;
    chk("t2_wen", reg_wen, 1);
    chk("t2_waddr", reg_waddr, 16'h0038);
    chk("t2_wdata", reg_wdata, 64'hA5A5_0000_FFFF_0001);
    for (int i = 0; i < 5; i++) begin
      chk("t2_bvalid_hold", bvalid, 1);
      chk("t2_bresp", bresp, 2'b00);
      chk("t2_readies_low", {awready, wready}, 2'b00);
      tick;
    end
    bready = 1;
    tick;
    chk("t2_bdone", bvalid, 0);
    chk("t2_readies_up", {awready, wready}, 2'b11);
    bready = 0;
    chk("t2_wen_cnt", wen_cnt, 2);
    core_val = 64'hDEADBEEF00000001;
    chk("t3_arready", arready, 1);
    arvalid = 1; araddr = 32'h20;
    tick;
    arvalid = 0;
    chk("t3_ren", reg_ren, 1);
    chk("t3_raddr", reg_raddr, 16'h0020);
    chk("t3_arready_low", arready, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t3_wait_rvalid", rvalid, 0);
      chk("t3_wait_ren", reg_ren, 0);
      chk("t3_raddr_stable", reg_raddr, 16'h0020);
    end
    tick;
    chk("t3_rvalid", rvalid, 1);
    chk("t3_rdata", rdata, 64'hDEADBEEF00000001);
    chk("t3_rresp", rresp, 2'b00);
    tick;
    chk("t3_rvalid_hold", rvalid, 1);
    chk("t3_rdata_hold", rdata, 64'hDEADBEEF00000001);
    rready = 1;
    tick;
    chk("t3_rdone", rvalid, 0);
    rready = 0;
    chk("t3_ren_cnt", ren_cnt, 1);
    bready = 1; rready = 1;
    awvalid = 1; awaddr = 32'h18; wvalid = 1; wdata = 64'hFFFF; wstrb = 8'h0F;
    tick;
    awvalid = 0; wvalid = 0;
    tick;
    chk("t4_bvalid", bvalid, 1);
    chk("t4_bresp", bresp, 2'b10);
    chk("t4_no_wen", reg_wen, 0);
    tick;
    chk("t4_bdone", bvalid, 0);
    arvalid = 1; araddr = 32'h10000;
    tick;
    arvalid = 0;
    chk("t4_no_ren", reg_ren, 0);
    repeat (4) tick;
    chk("t4_rvalid", rvalid, 1);
    chk("t4_rresp", rresp, 2'b10);
    chk("t4_rdata", rdata, 0);
    tick;
    chk("t4_rdone", rvalid, 0);
    chk("t4_wen_cnt", wen_cnt, 2);
    chk("t4_ren_cnt", ren_cnt, 1);
    awaddr = 32'h40; wdata = 64'h5555; wstrb = 8'hFF; araddr = 32'h48; core_val = 64'h77;
    log_on = 1;
    awvalid = 1; wvalid = 1;
    tick;
    arvalid = 1;
    repeat (70) tick;
    awvalid = 0; wvalid = 0; arvalid = 0;
    repeat (20) tick;
    log_on = 0;
    chk("t5_count", nseq >= 8, 1);
    for (int i = 0; i < 8; i++) chk($sformatf("t5_order%0d", i), seq[i], (i % 2) == 0);
    chk("t5_no_overlap", both_cnt, 0);
    chk("t6_arready", arready, 1);
    arvalid = 1; araddr = 32'h28;
    tick;
    arvalid = 0;
    chk("t6_ren", reg_ren, 1);
    tick;
    ps_rst = 1;
    tick;
    chk("t6_rst_readies", {awready, wready, arready}, 3'b000);
    chk("t6_rst_valids", {bvalid, rvalid, reg_wen, reg_ren}, 4'b0000);
    chk("t6_rst_raddr", reg_raddr, 0);
    chk("t6_rst_waddr", reg_waddr, 0);
    chk("t6_rst_wdata", reg_wdata, 0);
    chk("t6_rst_rdata", rdata, 0);
    chk("t6_rst_resp", {bresp, rresp}, 4'b0000);
    ps_rst = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("t6_no_rvalid", rvalid, 0);
    end
    core_val = 64'h0123456789ABCDEF;
    chk("t6_arready_again", arready, 1);
    arvalid = 1; araddr = 32'h30;
    tick;
    arvalid = 0;
    chk("t6_ren2", reg_ren, 1);
    chk("t6_raddr2", reg_raddr, 16'h0030);
    repeat (4) tick;
    chk("t6_rvalid2", rvalid, 1);
    chk("t6_rdata2", rdata, 64'h0123456789ABCDEF);
    chk("t6_rresp2", rresp, 2'b00);
    tick;
    chk("t6_rdone2", rvalid, 0);
    chk("end_no_overlap", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
